mc_core_ctrl: RTL
=================

Name: mc_core_ctrl

Overview:
Multi-cycle sequencer that replaces the single-cycle control path of our RV32I core. It lets one shared, variable-latency memory serve both instruction fetch and data access. It drives all datapath enables and mux selects from a state machine and handshakes with memory through req/ready. It also adds illegal-opcode trapping, an optional BNE branch mode, and a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter (wraps)
BRANCH_EXT, 0, 1 = funct3 001 (bne) also legal in BRANCH state

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write qualifier for mem_req
adr_src  out  1  0 = PC, 1 = ALUOut as memory address
ir_write  out  1  load instruction and old-PC registers
pc_write  out  1  load PC from result mux
reg_write  out  1  register file write enable
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1 data
alu_src_b  out  2  00 = rs2 data, 01 = immExt, 10 = constant 4
alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu
result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result direct
imm_src  out  3  000 I, 001 S, 010 B, 011 J
state_o  out  4  current state encoding, for debug
illegal  out  1  sticky trap flag
retired  out  CNT_WIDTH  count of completed instructions

Behaviour:
- Reset (async): state = FETCH, illegal = 0, retired = 0. While reset is high, all enables and selects are 0. Reset asserted mid-access aborts the access with no write.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXER=6, EXEI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=15.
- Outputs are Moore except pc_write, ir_write and reg_write, which are gated as stated below.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, add, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a = 01, alu_src_b = 01, add, imm_src = 010 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXER
  - 0010011 -> EXEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> TRAP
- MEMADR: alu_src_a = 10, alu_src_b = 01, add. imm_src = 000 for loads, 001 for stores. Next: MEMRD for loads, MEMWR for stores.
- MEMRD: mem_req = 1, adr_src = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src = 01, reg_write = 1, then go to FETCH.
- MEMWR: mem_req = 1, mem_we = 1, adr_src = 1. Wait for mem_ready, then go to FETCH.
- EXER: alu_src_a = 10, alu_src_b = 00. ALU op from funct3: 000 add, or sub if funct7b5; 111 and; 110 or; 100 xor; 010 slt; 011 sltu; 001 sll; 101 srl, or sra if funct7b5. Next: ALUWB.
- EXEI: alu_src_a = 10, alu_src_b = 01, imm_src = 000. Same ALU map as EXER except funct3 000 is always add; funct7b5 selects sra only for funct3 101. Next: ALUWB.
- ALUWB: result_src = 00, reg_write = 1, then go to FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, sub, result_src = 00.
  - pc_write = zero when funct3 = 000.
  - pc_write = ~zero when funct3 = 001 and BRANCH_EXT = 1.
  - Any other funct3 -> TRAP, no pc_write.
  - Otherwise go to FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1, imm_src = 011. Next: ALUWB (writes PC+4).
- TRAP: illegal = 1. All enables 0. Held until reset.
- retired increments by 1 on every transition into FETCH from a non-FETCH state, except out of TRAP. Wraps at 2^CNT_WIDTH.
- Memory handshake: mem_ready is sampled in the same cycle as mem_req, so zero-wait memory completes in 1 cycle. mem_req stays high until mem_ready is seen. mem_ready is ignored when mem_req = 0.
- Latency with zero-wait memory: beq 3, sw 4, R/I/jal 4, lw 5 cycles. Each wait cycle adds 1.

Test Plan:
- Reset while in MEMWR with mem_ready = 0 -> state_o = 0, mem_req = 0, retired = 0 immediately. First cycle after reset release: mem_req = 1, adr_src = 0.
- FETCH with mem_ready low for 3 cycles, then lw (0000011) with zero-wait memory -> ir_write high only in the 4th cycle; state sequence 0, 0, 0, 0, 1, 2, 3, 4, 0; reg_write only in state 4; retired = 1.
- R-type funct3 = 000 with funct7b5 = 1 -> alu_control = 0001 in EXER. I-type funct3 = 000 with funct7b5 = 1 -> alu_control = 0000. I-type funct3 = 101 with funct7b5 = 1 -> 1000.
- beq with zero = 1 -> pc_write = 1 in BRANCH. With zero = 0 -> pc_write = 0. With BRANCH_EXT = 0, funct3 = 001 -> TRAP, illegal = 1.
- Opcode 1110011 -> DECODE then TRAP. illegal stays 1 for 100 cycles, mem_req = 0, retired unchanged. Reset clears illegal.
- CNT_WIDTH = 4, 17 back-to-back sw instructions -> retired = 1 (wrap); mem_we high only in MEMWR.

Source files
------------

// File: rtl/mc_core_ctrl.sv
// mc_core_ctrl: multi-cycle RV32I control sequencer sharing one variable-latency
// memory between instruction fetch and data access.
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   opcode/funct3/funct7b5: instruction fields from the instruction register
//   zero                 : ALU zero flag, current cycle
//   mem_ready            : memory completes the requested access this cycle
//   mem_req/mem_we/adr_src: memory request, write qualifier, address select
//   ir_write/pc_write/reg_write: datapath enables
//   alu_src_a/alu_src_b/alu_control/result_src/imm_src: datapath selects
//   state_o              : current state (debug)
//   illegal              : sticky illegal-instruction trap flag
//   retired              : wrapping count of completed instructions
module mc_core_ctrl #(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter bit          BRANCH_EXT = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_control,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_src,
    output logic [3:0]           state_o,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t                state_q, state_d;
    logic                  illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic                  branch_ok;
    logic                  branch_take;

    // funct3 -> ALU op; sub_ok distinguishes R-type (add/sub) from I-type (add only)
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sub_ok,
                                          input logic f7);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (sub_ok && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // beq always legal; bne only when the extension is built in
    assign branch_ok   = (funct3 == 3'b000) || (BRANCH_EXT && (funct3 == 3'b001));
    assign branch_take = ((funct3 == 3'b000) && zero) ||
                         (BRANCH_EXT && (funct3 == 3'b001) && !zero);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXER;
                    OP_ITYPE:          state_d = S_EXEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXER:   state_d = S_ALUWB;
            S_EXEI:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = branch_ok ? S_FETCH : S_TRAP;
            S_JAL:    state_d = S_ALUWB;
            default:  state_d = S_TRAP;
        endcase
    end

    // Trap flag is sticky; retire count bumps on each return to FETCH
    always_comb begin
        illegal_d = illegal_q | (state_d == S_TRAP);
        retired_d = retired_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP)) begin
            retired_d = retired_q + CNT_WIDTH'(1);
        end
    end

    // State and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Moore decode; enables gated by mem_ready/zero; everything forced low in reset
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        result_src  = 2'b00;
        imm_src     = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            S_EXER: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op(funct3, 1'b1, funct7b5);
            end
            S_EXEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op(funct3, 1'b0, funct7b5);
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = branch_take;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                imm_src   = 3'b011;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            adr_src     = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_control = ALU_ADD;
            result_src  = 2'b00;
            imm_src     = 3'b000;
        end
    end

    assign state_o = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule
